// File: rtl/tsn_frame_gen_if.sv
// 8-bit AXI-Stream link carrying TSN test frames toward the MAC TX FIFO.
interface tsn_frame_gen_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/tsn_frame_gen.sv
// One Ethernet test frame (seq number + PTP timestamp) per accepted tx trigger.
// Optional 802.1Q tag insertion when TSN_VLAN_TAG_EN is defined.
module tsn_frame_gen #(
  parameter int          FRAME_LEN = 60,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter logic [2:0]  VLAN_PCP  = 3'd7,
  parameter logic [11:0] VLAN_VID  = 12'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_trigger,
  input  logic                  enable,
  input  logic [63:0]           time_ptp_ns,
  input  logic [47:0]           dst_mac,
  input  logic [47:0]           src_mac,
  tsn_frame_gen_if.master       m_axis,
  output logic                  busy,
  output logic [31:0]           seq_num,
  output logic [15:0]           overrun_cnt
);

`ifdef TSN_VLAN_TAG_EN
  localparam int TAG_LEN = 4;
`else
  localparam int TAG_LEN = 0;
`endif
  localparam logic [10:0] LAST_IDX  = 11'(FRAME_LEN + TAG_LEN - 1);
  localparam int          HDR_BYTES = 30;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [31:0] seq;
    logic [63:0] ts;
  } frame_hdr_t;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state, state_nxt;
  frame_hdr_t               hdr;
  logic [10:0]              byte_idx;
  logic [10:0]              full_idx;
  logic [HDR_BYTES*8-1:0]   hdr_bits;
  logic                     trig, start, fire, at_last;

  assign trig    = enable && tx_trigger;
  assign at_last = (byte_idx == LAST_IDX);
  assign busy    = (state == SEND);

  // Header always holds the tag; untagged frames simply skip over its 4 bytes.
  assign hdr_bits = {hdr.dst, hdr.src, 16'h8100, VLAN_PCP, 1'b0, VLAN_VID,
                     ETHERTYPE, hdr.seq, hdr.ts};

  always_comb begin
    state_nxt     = state;
    start         = 1'b0;
    fire          = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    m_axis.tdata  = 8'h00;
    full_idx      = byte_idx;
    if (TAG_LEN == 0 && byte_idx >= 11'd12) full_idx = byte_idx + 11'd4;
    case (state)
      IDLE: if (trig) begin
        start     = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        m_axis.tvalid = 1'b1;
        m_axis.tlast  = at_last;
        if (full_idx < 11'(HDR_BYTES))
          m_axis.tdata = hdr_bits[(HDR_BYTES - 1 - int'(full_idx)) * 8 +: 8];
        fire = m_axis.tready;
        if (fire && at_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      byte_idx    <= '0;
      hdr         <= '0;
      seq_num     <= '0;
      overrun_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        hdr      <= {dst_mac, src_mac, seq_num, time_ptp_ns};
        byte_idx <= '0;
      end
      if (fire) begin
        if (at_last) begin
          byte_idx <= '0;
          seq_num  <= seq_num + 32'd1;
        end else begin
          byte_idx <= byte_idx + 11'd1;
        end
      end
      // A trigger landing while busy (tlast handshake included) is lost, not queued.
      if (busy && trig && overrun_cnt != 16'hFFFF)
        overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tsn_frame_gen.sv
// Randomized + directed bench for tsn_frame_gen against a frame-level reference model.
module tb_tsn_frame_gen;
  localparam int FRAME_LEN = 60;
`ifdef TSN_VLAN_TAG_EN
  localparam int TAG = 4;
`else
  localparam int TAG = 0;
`endif
  localparam int LEN = FRAME_LEN + TAG;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_trigger = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] time_ptp_ns = '0;
  logic [47:0] dst_mac = '0;
  logic [47:0] src_mac = '0;
  logic        busy;
  logic [31:0] seq_num;
  logic [15:0] overrun_cnt;

  tsn_frame_gen_if axis();

  tsn_frame_gen dut (
    .clk(clk), .rst(rst), .tx_trigger(tx_trigger), .enable(enable),
    .time_ptp_ns(time_ptp_ns), .dst_mac(dst_mac), .src_mac(src_mac),
    .m_axis(axis), .busy(busy), .seq_num(seq_num), .overrun_cnt(overrun_cnt)
  );

  always #4 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level state, advanced once per clock from the inputs.
  logic        m_busy = 1'b0;
  int          m_idx = 0;
  logic [31:0] m_seq = '0;
  logic [15:0] m_ovr = '0;
  logic [31:0] m_fseq = '0;
  logic [63:0] m_ts = '0;
  logic [47:0] m_dst = '0;
  logic [47:0] m_src = '0;

  function automatic logic [7:0] exp_byte(input int i);
    int j;
    j = i;
    if (i < 6)  return 8'(m_dst >> (8 * (5 - i)));
    if (i < 12) return 8'(m_src >> (8 * (11 - i)));
    if (TAG == 4) begin
      if (i == 12) return 8'h81;
      if (i == 13) return 8'h00;
      if (i == 14) return 8'hE0;
      if (i == 15) return 8'h01;
      j = i - 4;
    end
    if (j == 12) return 8'h88;
    if (j == 13) return 8'hB5;
    if (j < 18) return 8'(m_fseq >> (8 * (17 - j)));
    if (j < 26) return 8'(m_ts >> (8 * (25 - j)));
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_idx  <= 0;
      m_seq  <= '0;
      m_ovr  <= '0;
    end else if (m_busy) begin
      if (enable && tx_trigger && m_ovr != 16'hFFFF) m_ovr <= m_ovr + 16'd1;
      if (axis.tready) begin
        if (m_idx == LEN - 1) begin
          m_busy <= 1'b0;
          m_seq  <= m_seq + 32'd1;
        end else begin
          m_idx <= m_idx + 1;
        end
      end
    end else if (enable && tx_trigger) begin
      m_busy <= 1'b1;
      m_idx  <= 0;
      m_fseq <= m_seq;
      m_ts   <= time_ptp_ns;
      m_dst  <= dst_mac;
      m_src  <= src_mac;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("tvalid", axis.tvalid, m_busy);
      chk("busy", busy, m_busy);
      chk("seq_num", seq_num, m_seq);
      chk("overrun_cnt", overrun_cnt, m_ovr);
      chk("tdata", axis.tdata, m_busy ? exp_byte(m_idx) : 8'h00);
      chk("tlast", axis.tlast, m_busy && (m_idx == LEN - 1));
    end
  end

  // Handshaked bytes, in order, for literal frame checks.
  logic [7:0] cap [0:8191];
  int         ncap = 0;
  always @(negedge clk) begin
    if (axis.tvalid && axis.tready) begin
      if (ncap < 8192) cap[ncap] <= axis.tdata;
      ncap <= ncap + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic trigger(input logic [63:0] t);
    time_ptp_ns = t;
    tx_trigger  = 1'b1;
    tick();
    tx_trigger  = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (busy && k < bound) begin
      tick();
      k++;
    end
    chk("wait_idle_timeout", busy, 1'b0);
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] t1 [0:LEN-1];
  int base;
  int k;

  initial begin
    axis.tready = 1'b1;
    tick();
    tick();
    chk_on = 1'b1;
    rst = 1'b0;
    chk("rst_tvalid", axis.tvalid, 1'b0);
    chk("rst_tdata", axis.tdata, 8'h00);
    chk("rst_seq", seq_num, 32'd0);
    chk("rst_ovr", overrun_cnt, 16'd0);

    // T1: basic frame
    enable  = 1'b1;
    dst_mac = 48'h0A0B0C0D0E0F;
    src_mac = 48'h102030405060;
    base    = ncap;
    trigger(64'h1122334455667788);
    chk("t1_latency", axis.tvalid, 1'b1);
    wait_idle(200);
    tick();
    chk("t1_len", ncap - base, LEN);
    chk("t1_dst0", cap[base], 8'h0A);
    chk("t1_src5", cap[base + 11], 8'h60);
    chk("t1_b12", cap[base + 12], (TAG == 4) ? 8'h81 : 8'h88);
    for (int i = 0; i < 4; i++) chk("t1_seq", cap[base + 14 + TAG + i], 8'h00);
    for (int i = 0; i < 8; i++) chk("t1_ts", cap[base + 18 + TAG + i], 8'(8'h11 * (i + 1)));
    chk("t1_pad", cap[base + LEN - 1], 8'h00);
    chk("t1_seq_after", seq_num, 32'd1);
    for (int i = 0; i < LEN; i++) t1[i] = cap[base + i];

    // T2: tready toggling every cycle
    base = ncap;
    trigger(64'h1122334455667788);
    k = 0;
    while (busy && k < 400) begin
      axis.tready = ~axis.tready;
      tick();
      k++;
    end
    chk("t2_timeout", busy, 1'b0);
    axis.tready = 1'b1;
    tick();
    chk("t2_len", ncap - base, LEN);
    for (int i = 0; i < LEN; i++)
      chk("t2_byte", cap[base + i], (i == 17 + TAG) ? 8'h01 : t1[i]);

    // T3: overruns mid-frame and on the tlast handshake
    pulse_rst();
    base = ncap;
    trigger(64'hA5);
    repeat (20) tick();
    trigger(64'hB6);
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (axis.tlast) break;
      k++;
    end
    chk("t3_tlast_timeout", axis.tlast, 1'b1);
    tx_trigger = 1'b1;
    tick();
    tx_trigger = 1'b0;
    repeat (5) tick();
    chk("t3_ovr", overrun_cnt, 16'd2);
    chk("t3_frames", ncap - base, LEN);
    chk("t3_seq", seq_num, 32'd1);

    // T4: enable low, then enable dropped mid-frame
    pulse_rst();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      trigger(64'(i));
      chk("t4_no_tvalid", axis.tvalid, 1'b0);
      tick();
    end
    chk("t4_ovr", overrun_cnt, 16'd0);
    enable = 1'b1;
    base   = ncap;
    trigger(64'hC7);
    repeat (10) tick();
    enable = 1'b0;
    wait_idle(200);
    trigger(64'hD8);
    tick();
    chk("t4_len", ncap - base, LEN);
    chk("t4_idle", busy, 1'b0);

    // T5: reset mid-frame at byte 30
    enable = 1'b1;
    base   = ncap;
    trigger(64'hE9);
    k = 0;
    while (ncap - base < 30 && k < 200) begin
      tick();
      k++;
    end
    chk("t5_reach30", ncap - base, 30);
    pulse_rst();
    chk("t5_tvalid", axis.tvalid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_seq", seq_num, 32'd0);
    base = ncap;
    trigger(64'hFA);
    wait_idle(200);
    tick();
    chk("t5_len", ncap - base, LEN);
    for (int i = 0; i < 4; i++) chk("t5_seqbyte", cap[base + 14 + TAG + i], 8'h00);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      enable      = ($urandom % 8) != 0;
      tx_trigger  = ($urandom % 16) == 0;
      axis.tready = ($urandom % 4) != 0;
      rst         = ($urandom % 1000) == 0;
      time_ptp_ns = {$urandom, $urandom};
      dst_mac     = 48'({$urandom, $urandom});
      src_mac     = 48'({$urandom, $urandom});
      tick();
    end
    rst         = 1'b0;
    tx_trigger  = 1'b0;
    enable      = 1'b0;
    axis.tready = 1'b1;
    wait_idle(200);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
